muldiv_unit: RTL and testbench

- Iterative multi-cycle execution unit for RV32M: MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU.
- Sits beside the single-cycle ALU in EX and consumes the 5-bit ALUCtrl code produced by the control unit.
- Stalls the pipeline through busy until a one-cycle done pulse presents the result.

---
 rtl/muldiv_unit_pkg.sv | 45 ++++
 rtl/muldiv_sign_fix.sv | 12 +
 rtl/muldiv_unit.sv | 206 ++++++++++++++++++++
 tb/tb_muldiv_unit.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_unit_pkg.sv
// Shared ALU control encodings, muldiv FSM state encodings and M-op decode helpers.
// Consumed by muldiv_unit and its bench.
package muldiv_unit_pkg;

   localparam logic [4:0] ALUCTRL_ADD    = 5'b00000;
   localparam logic [4:0] ALUCTRL_SUB    = 5'b00001;
   localparam logic [4:0] ALUCTRL_MUL    = 5'b10000;
   localparam logic [4:0] ALUCTRL_MULH   = 5'b10001;
   localparam logic [4:0] ALUCTRL_MULHSU = 5'b10010;
   localparam logic [4:0] ALUCTRL_MULHU  = 5'b10011;
   localparam logic [4:0] ALUCTRL_DIV    = 5'b10100;
   localparam logic [4:0] ALUCTRL_DIVU   = 5'b10101;
   localparam logic [4:0] ALUCTRL_REM    = 5'b10110;
   localparam logic [4:0] ALUCTRL_REMU   = 5'b10111;

   typedef enum logic [1:0] {
      MD_IDLE = 2'b00,
      MD_CALC = 2'b01,
      MD_FIX  = 2'b10,
      MD_DONE = 2'b11
   } md_state_e;

   function automatic logic is_mop(input logic [4:0] code);
      case (code)
         ALUCTRL_MUL, ALUCTRL_MULH, ALUCTRL_MULHSU, ALUCTRL_MULHU,
         ALUCTRL_DIV, ALUCTRL_DIVU, ALUCTRL_REM, ALUCTRL_REMU: return 1'b1;
         default: return 1'b0;
      endcase
   endfunction

   function automatic logic is_div(input logic [4:0] code);
      case (code)
         ALUCTRL_DIV, ALUCTRL_DIVU, ALUCTRL_REM, ALUCTRL_REMU: return 1'b1;
         default: return 1'b0;
      endcase
   endfunction

   function automatic logic is_quot(input logic [4:0] code);
      case (code)
         ALUCTRL_DIV, ALUCTRL_DIVU: return 1'b1;
         default: return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/muldiv_sign_fix.sv
// Conditional two's-complement negate; yields |x| at accept and restores the sign in FIX.
module muldiv_sign_fix #(
   parameter int W = 32
) (
   input  logic [W-1:0] val,
   input  logic         neg,
   output logic [W-1:0] res
);

   assign res = (val ^ {W{neg}}) + {{(W-1){1'b0}}, neg};

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit (shift-add multiply, restoring divide).
// Define MULDIV_FAST_MUL_EN for a single-cycle multiply computed in the accept cycle.
module muldiv_unit
   import muldiv_unit_pkg::*;
#(
   parameter int BITS = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   input  logic [4:0]      ALUCtrl,
   input  logic [BITS-1:0] op_a,
   input  logic [BITS-1:0] op_b,
   input  logic            flush,
   output logic            busy,
   output logic            done,
   output logic [BITS-1:0] result
);

   localparam int CNT_W = $clog2(BITS) + 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BITS - 1);
   localparam logic [BITS-1:0]  ALL_ONES = {BITS{1'b1}};
   localparam logic [BITS-1:0]  ZERO     = {BITS{1'b0}};
   localparam logic [BITS-1:0]  MIN_NEG  = {1'b1, {(BITS-1){1'b0}}};

   md_state_e         state_r;
   logic [4:0]        op_r;
   logic              neg_res_r;
   logic              neg_rem_r;
   logic [BITS-1:0]   mag_a_r;
   logic [BITS-1:0]   mag_b_r;
   logic [2*BITS-1:0] prod_r;
   logic [CNT_W-1:0]  cnt_r;
   logic [BITS-1:0]   result_r;
   logic              done_r;

   logic              signed_a_s;
   logic              signed_b_s;
   logic              sign_a_s;
   logic              sign_b_s;
   logic [BITS-1:0]   mag_a_s;
   logic [BITS-1:0]   mag_b_s;
   logic              accept_s;
   logic              special_s;
   logic [BITS-1:0]   special_res_s;
   logic [BITS:0]     mul_sum_s;
   logic [BITS:0]     div_diff_s;
   logic [2*BITS-1:0] calc_next_s;
   logic [2*BITS-1:0] prod_fix_s;
   logic [BITS-1:0]   quot_fix_s;
   logic [BITS-1:0]   rem_fix_s;
   logic [BITS-1:0]   fix_res_s;

   assign busy   = (state_r != MD_IDLE);
   assign done   = done_r;
   assign result = result_r;

   // Operand signedness for the incoming operation.
   always_comb begin
      signed_a_s = 1'b0;
      signed_b_s = 1'b0;
      case (ALUCtrl)
         ALUCTRL_MUL, ALUCTRL_MULH, ALUCTRL_DIV, ALUCTRL_REM: begin
            signed_a_s = 1'b1;
            signed_b_s = 1'b1;
         end
         ALUCTRL_MULHSU: begin
            signed_a_s = 1'b1;
            signed_b_s = 1'b0;
         end
         default: begin
            signed_a_s = 1'b0;
            signed_b_s = 1'b0;
         end
      endcase
   end

   assign sign_a_s = signed_a_s & op_a[BITS-1];
   assign sign_b_s = signed_b_s & op_b[BITS-1];
   assign accept_s = (state_r == MD_IDLE) && start && !flush && is_mop(ALUCtrl);

   muldiv_sign_fix #(.W(BITS)) u_mag_a (.val(op_a), .neg(sign_a_s), .res(mag_a_s));
   muldiv_sign_fix #(.W(BITS)) u_mag_b (.val(op_b), .neg(sign_b_s), .res(mag_b_s));

   // Divide-by-zero and signed-overflow results, resolved without iterating.
   always_comb begin
      special_s     = 1'b0;
      special_res_s = ZERO;
      if (is_div(ALUCtrl) && (op_b == ZERO)) begin
         special_s     = 1'b1;
         special_res_s = is_quot(ALUCtrl) ? ALL_ONES : op_a;
      end else if (((ALUCtrl == ALUCTRL_DIV) || (ALUCtrl == ALUCTRL_REM)) &&
                   (op_a == MIN_NEG) && (op_b == ALL_ONES)) begin
         special_s     = 1'b1;
         special_res_s = (ALUCtrl == ALUCTRL_DIV) ? op_a : ZERO;
      end else begin
         special_s     = 1'b0;
         special_res_s = ZERO;
      end
   end

   // prod_r is {acc, multiplier} for multiply and {remainder, quotient} for divide.
   assign mul_sum_s  = {1'b0, prod_r[2*BITS-1:BITS]} + (prod_r[0] ? {1'b0, mag_a_r} : {(BITS+1){1'b0}});
   assign div_diff_s = prod_r[2*BITS-1:BITS-1] - {1'b0, mag_b_r};
   assign calc_next_s = !is_div(op_r) ? {mul_sum_s, prod_r[BITS-1:1]} :
                        div_diff_s[BITS] ? {prod_r[2*BITS-2:0], 1'b0} :
                        {div_diff_s[BITS-1:0], prod_r[BITS-2:0], 1'b1};

`ifdef MULDIV_FAST_MUL_EN
   logic [2*BITS-1:0] sext_a_s;
   logic [2*BITS-1:0] sext_b_s;
   logic [2*BITS-1:0] fast_prod_s;
   assign sext_a_s    = {{BITS{sign_a_s}}, op_a};
   assign sext_b_s    = {{BITS{sign_b_s}}, op_b};
   assign fast_prod_s = sext_a_s * sext_b_s;
`endif

   muldiv_sign_fix #(.W(2*BITS)) u_fix_prod (.val(prod_r), .neg(neg_res_r), .res(prod_fix_s));
   muldiv_sign_fix #(.W(BITS)) u_fix_quot (.val(prod_r[BITS-1:0]), .neg(neg_res_r), .res(quot_fix_s));
   muldiv_sign_fix #(.W(BITS)) u_fix_rem (.val(prod_r[2*BITS-1:BITS]), .neg(neg_rem_r), .res(rem_fix_s));

   // Final result selection in FIX.
   always_comb begin
      fix_res_s = ZERO;
      case (op_r)
         ALUCTRL_MUL:                                  fix_res_s = prod_fix_s[BITS-1:0];
         ALUCTRL_MULH, ALUCTRL_MULHSU, ALUCTRL_MULHU:  fix_res_s = prod_fix_s[2*BITS-1:BITS];
         ALUCTRL_DIV, ALUCTRL_DIVU:                    fix_res_s = quot_fix_s;
         ALUCTRL_REM, ALUCTRL_REMU:                    fix_res_s = rem_fix_s;
         default:                                      fix_res_s = ZERO;
      endcase
   end

   // Control FSM and datapath registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r   <= MD_IDLE;
         op_r      <= 5'b00000;
         neg_res_r <= 1'b0;
         neg_rem_r <= 1'b0;
         mag_a_r   <= ZERO;
         mag_b_r   <= ZERO;
         prod_r    <= {(2*BITS){1'b0}};
         cnt_r     <= {CNT_W{1'b0}};
         result_r  <= ZERO;
         done_r    <= 1'b0;
      end else if (flush) begin
         state_r <= MD_IDLE;
         cnt_r   <= {CNT_W{1'b0}};
         done_r  <= 1'b0;
      end else begin
         case (state_r)
            MD_IDLE: begin
               done_r <= 1'b0;
               if (accept_s) begin
                  op_r      <= ALUCtrl;
                  neg_res_r <= sign_a_s ^ sign_b_s;
                  neg_rem_r <= sign_a_s;
                  mag_a_r   <= mag_a_s;
                  mag_b_r   <= mag_b_s;
                  cnt_r     <= {CNT_W{1'b0}};
                  if (special_s) begin
                     result_r <= special_res_s;
                     done_r   <= 1'b1;
                     state_r  <= MD_DONE;
                  end
`ifdef MULDIV_FAST_MUL_EN
                  else if (!is_div(ALUCtrl)) begin
                     prod_r    <= fast_prod_s;
                     neg_res_r <= 1'b0;
                     state_r   <= MD_FIX;
                  end
`endif
                  else begin
                     prod_r  <= {ZERO, is_div(ALUCtrl) ? mag_a_s : mag_b_s};
                     state_r <= MD_CALC;
                  end
               end
            end
            MD_CALC: begin
               prod_r <= calc_next_s;
               if (cnt_r == CNT_LAST) begin
                  cnt_r   <= {CNT_W{1'b0}};
                  state_r <= MD_FIX;
               end else begin
                  cnt_r <= cnt_r + CNT_W'(1);
               end
            end
            MD_FIX: begin
               result_r <= fix_res_s;
               done_r   <= 1'b1;
               state_r  <= MD_DONE;
            end
            MD_DONE: begin
               done_r  <= 1'b0;
               state_r <= MD_IDLE;
            end
            default: begin
               done_r  <= 1'b0;
               state_r <= MD_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit with hand-computed RV32M results.
module tb_muldiv_unit;
   import muldiv_unit_pkg::*;

`ifdef MULDIV_FAST_MUL_EN
   localparam int MUL_LAT = 2;
`else
   localparam int MUL_LAT = 34;
`endif
   localparam int DIV_LAT = 34;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [4:0]  alu_ctrl;
   logic [31:0] op_a;
   logic [31:0] op_b;
   logic        flush;
   logic        busy;
   logic        done;
   logic [31:0] result;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   muldiv_unit #(.BITS(32)) dut (
      .clk(clk),
      .rst(rst),
      .start(start),
      .ALUCtrl(alu_ctrl),
      .op_a(op_a),
      .op_b(op_b),
      .flush(flush),
      .busy(busy),
      .done(done),
      .result(result)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic run_op(input string tag, input logic [4:0] code, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp, input int lat);
      int cyc;
      alu_ctrl = code;
      op_a     = a;
      op_b     = b;
      start    = 1'b1;
      tick();
      start = 1'b0;
      cyc   = 1;
      while (done !== 1'b1 && cyc < 60) begin
         tick();
         cyc++;
      end
      check({tag, "/done"}, {31'd0, done}, 32'd1);
      check({tag, "/latency"}, 32'(cyc), 32'(lat));
      check({tag, "/busy_in_done"}, {31'd0, busy}, 32'd1);
      check({tag, "/result"}, result, exp);
      tick();
      check({tag, "/done_cleared"}, {31'd0, done}, 32'd0);
      check({tag, "/idle_after"}, {31'd0, busy}, 32'd0);
      check({tag, "/result_held"}, result, exp);
   endtask

   initial begin
      int cyc;
      int pulses;
      rst      = 1'b1;
      start    = 1'b0;
      flush    = 1'b0;
      alu_ctrl = ALUCTRL_ADD;
      op_a     = 32'd0;
      op_b     = 32'd0;
      repeat (2) @(posedge clk);
      #1;
      check("reset/busy", {31'd0, busy}, 32'd0);
      check("reset/done", {31'd0, done}, 32'd0);
      check("reset/result", result, 32'd0);
      rst = 1'b0;
      tick();

      // Multiplies
      run_op("mul_7_m3", ALUCTRL_MUL, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, MUL_LAT);
      run_op("mul_m5_m6", ALUCTRL_MUL, 32'hFFFF_FFFB, 32'hFFFF_FFFA, 32'h0000_001E, MUL_LAT);
      run_op("mulh_min", ALUCTRL_MULH, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, MUL_LAT);
      run_op("mulhsu_m1", ALUCTRL_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, MUL_LAT);
      run_op("mulhu_ones", ALUCTRL_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, MUL_LAT);
      run_op("mulhu_2p32", ALUCTRL_MULHU, 32'h0001_0000, 32'h0001_0000, 32'h0000_0001, MUL_LAT);

      // Divides
      run_op("div_m7_2", ALUCTRL_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, DIV_LAT);
      run_op("rem_m7_2", ALUCTRL_REM, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, DIV_LAT);
      run_op("divu_big", ALUCTRL_DIVU, 32'hFFFF_FFFE, 32'd2, 32'h7FFF_FFFF, DIV_LAT);
      run_op("div_100_m7", ALUCTRL_DIV, 32'd100, 32'hFFFF_FFF9, 32'hFFFF_FFF2, DIV_LAT);
      run_op("rem_100_m7", ALUCTRL_REM, 32'd100, 32'hFFFF_FFF9, 32'd2, DIV_LAT);

      // Special divide cases complete one cycle after accept
      run_op("div_by_0", ALUCTRL_DIV, 32'h0000_1234, 32'd0, 32'hFFFF_FFFF, 1);
      run_op("remu_by_0", ALUCTRL_REMU, 32'd5, 32'd0, 32'd5, 1);
      run_op("div_ovf", ALUCTRL_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
      run_op("rem_ovf", ALUCTRL_REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1);

      // A start while busy must not disturb the running divide
      alu_ctrl = ALUCTRL_DIV;
      op_a     = 32'd100;
      op_b     = 32'd7;
      start    = 1'b1;
      tick();
      start = 1'b0;
      cyc   = 1;
      repeat (2) begin
         tick();
         cyc++;
      end
      alu_ctrl = ALUCTRL_DIVU;
      op_a     = 32'd1;
      op_b     = 32'd1;
      start    = 1'b1;
      tick();
      start = 1'b0;
      cyc++;
      while (done !== 1'b1 && cyc < 60) begin
         tick();
         cyc++;
      end
      check("busy_start/latency", 32'(cyc), 32'(DIV_LAT));
      check("busy_start/result", result, 32'd14);
      tick();
      check("busy_start/idle_after", {31'd0, busy}, 32'd0);

      // Flush during cycle 10 of a divide
      alu_ctrl = ALUCTRL_DIV;
      op_a     = 32'hFFFF_FF9C;
      op_b     = 32'd7;
      start    = 1'b1;
      tick();
      start = 1'b0;
      repeat (9) tick();
      flush = 1'b1;
      tick();
      flush = 1'b0;
      check("flush/busy", {31'd0, busy}, 32'd0);
      check("flush/done", {31'd0, done}, 32'd0);
      pulses = 0;
      for (int i = 0; i < 40; i++) begin
         tick();
         if (done === 1'b1) pulses++;
      end
      check("flush/no_pulse", 32'(pulses), 32'd0);
      check("flush/result_kept", result, 32'd14);

      // Start coincident with flush is dropped
      alu_ctrl = ALUCTRL_MUL;
      op_a     = 32'd3;
      op_b     = 32'd3;
      start    = 1'b1;
      flush    = 1'b1;
      tick();
      start = 1'b0;
      flush = 1'b0;
      check("flush_start/busy", {31'd0, busy}, 32'd0);

      // Non-M code is ignored
      alu_ctrl = ALUCTRL_ADD;
      start    = 1'b1;
      tick();
      start = 1'b0;
      check("add_code/busy", {31'd0, busy}, 32'd0);
      pulses = 0;
      for (int i = 0; i < 3; i++) begin
         tick();
         if (done === 1'b1) pulses++;
      end
      check("add_code/no_pulse", 32'(pulses), 32'd0);
      check("add_code/result_kept", result, 32'd14);

      // Normal operation after the aborted ones
      run_op("remu_100_7", ALUCTRL_REMU, 32'd100, 32'd7, 32'd2, DIV_LAT);

      // Asynchronous reset in the middle of an operation
      alu_ctrl = ALUCTRL_DIV;
      op_a     = 32'd50;
      op_b     = 32'd3;
      start    = 1'b1;
      tick();
      start = 1'b0;
      repeat (4) tick();
      check("pre_rst/busy", {31'd0, busy}, 32'd1);
      rst = 1'b1;
      #1;
      check("mid_rst/busy", {31'd0, busy}, 32'd0);
      check("mid_rst/done", {31'd0, done}, 32'd0);
      check("mid_rst/result", result, 32'd0);
      tick();
      rst = 1'b0;
      tick();
      check("post_rst/busy", {31'd0, busy}, 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
